// File: rtl/fetch_redirect_ctrl_if.sv
// Request handshake from execute, fetch-side PC inputs and the redirect controls
// driven back into fetch, bundled for fetch_redirect_ctrl.
interface fetch_redirect_ctrl_if;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [2:0]  redirect_kind;
    logic [8:0]  redirect_offset;
    logic [5:0]  redirect_target;
    logic [19:0] fetch_pc;
    logic [19:0] fetch_prev_pc;
    logic [2:0]  pcjumpenable;
    logic [8:0]  pcchange;
    logic [5:0]  pclocation;
    logic        flush;
    logic        link_valid;
    logic [19:0] link_addr;
    logic        busy;
    logic        err;

    modport master (
        output redirect_valid, redirect_kind, redirect_offset, redirect_target,
               fetch_pc, fetch_prev_pc,
        input  redirect_ready, pcjumpenable, pcchange, pclocation, flush,
               link_valid, link_addr, busy, err
    );

    modport slave (
        input  redirect_valid, redirect_kind, redirect_offset, redirect_target,
               fetch_pc, fetch_prev_pc,
        output redirect_ready, pcjumpenable, pcchange, pclocation, flush,
               link_valid, link_addr, busy, err
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Owns fetch's redirect controls: drives a branch/jump until fetch_pc reaches the
// target, then flushes fetch and reports link addresses. One request can be queued.
module fetch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 15
) (
    input logic                  clock,
    input logic                  reset,
    fetch_redirect_ctrl_if.slave rif
);
    // state    | meaning
    // IDLE     | nothing outstanding, always ready
    // REDIRECT | driving kind/offset/target until fetch_pc matches or timeout
    // FLUSH    | flush held FLUSH_CYCLES cycles, then promote pending or idle
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] FL_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [2:0]  cur_kind, cur_kind_nxt;
    logic [19:0] cur_target, cur_target_nxt;
    logic [19:0] cur_base, cur_base_nxt;
    logic        pend_full, pend_full_nxt;
    logic [2:0]  pend_kind, pend_kind_nxt;
    logic [8:0]  pend_offset, pend_offset_nxt;
    logic [5:0]  pend_target, pend_target_nxt;
    logic [19:0] pend_base, pend_base_nxt;
    logic [7:0]  tmo_cnt, tmo_cnt_nxt;
    logic [2:0]  fl_cnt, fl_cnt_nxt;

    logic [2:0]  pcjumpenable_q, pcjumpenable_nxt;
    logic [8:0]  pcchange_q, pcchange_nxt;
    logic [5:0]  pclocation_q, pclocation_nxt;
    logic        flush_q, flush_nxt;
    logic        link_valid_q, link_valid_nxt;
    logic [19:0] link_addr_q, link_addr_nxt;
    logic        busy_q, busy_nxt;
    logic        err_q, err_nxt;

    logic        ready;
    logic        accept;
    logic        req_legal;
    logic        load_en;
    logic [2:0]  ld_kind;
    logic [8:0]  ld_offset;
    logic [5:0]  ld_target;
    logic [19:0] ld_base;

    function automatic logic kind_legal(input logic [2:0] k);
        return (k >= 3'd1) && (k <= 3'd4);
    endfunction

    function automatic logic kind_rel(input logic [2:0] k);
        return (k == 3'd1) || (k == 3'd4);
    endfunction

    function automatic logic kind_link(input logic [2:0] k);
        return (k == 3'd3) || (k == 3'd4);
    endfunction

    assign ready     = (state == ST_IDLE) || !pend_full;
    assign accept    = rif.redirect_valid && ready;
    assign req_legal = kind_legal(rif.redirect_kind);

    assign rif.redirect_ready = ready;
    assign rif.pcjumpenable   = pcjumpenable_q;
    assign rif.pcchange       = pcchange_q;
    assign rif.pclocation     = pclocation_q;
    assign rif.flush          = flush_q;
    assign rif.link_valid     = link_valid_q;
    assign rif.link_addr      = link_addr_q;
    assign rif.busy           = busy_q;
    assign rif.err            = err_q;

    always_comb begin
        state_nxt        = state;
        cur_kind_nxt     = cur_kind;
        cur_target_nxt   = cur_target;
        cur_base_nxt     = cur_base;
        pend_full_nxt    = pend_full;
        pend_kind_nxt    = pend_kind;
        pend_offset_nxt  = pend_offset;
        pend_target_nxt  = pend_target;
        pend_base_nxt    = pend_base;
        tmo_cnt_nxt      = tmo_cnt;
        fl_cnt_nxt       = fl_cnt;
        pcjumpenable_nxt = pcjumpenable_q;
        pcchange_nxt     = pcchange_q;
        pclocation_nxt   = pclocation_q;
        flush_nxt        = flush_q;
        link_valid_nxt   = 1'b0;
        link_addr_nxt    = link_addr_q;
        err_nxt          = 1'b0;
        load_en          = 1'b0;
        ld_kind          = rif.redirect_kind;
        ld_offset        = rif.redirect_offset;
        ld_target        = rif.redirect_target;
        ld_base          = rif.fetch_prev_pc;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_legal) load_en = 1'b1;
                    else           err_nxt = 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (accept) begin
                    if (req_legal) begin
                        pend_full_nxt   = 1'b1;
                        pend_kind_nxt   = rif.redirect_kind;
                        pend_offset_nxt = rif.redirect_offset;
                        pend_target_nxt = rif.redirect_target;
                        pend_base_nxt   = rif.fetch_prev_pc;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                // A match on the terminal-count cycle counts as completion, not timeout.
                if (rif.fetch_pc == cur_target) begin
                    state_nxt        = ST_FLUSH;
                    pcjumpenable_nxt = 3'd0;
                    flush_nxt        = 1'b1;
                    fl_cnt_nxt       = FL_LOAD;
                    if (kind_link(cur_kind)) begin
                        link_valid_nxt = 1'b1;
                        link_addr_nxt  = cur_base + 20'd1;
                    end
                end else if (tmo_cnt == 8'd0) begin
                    state_nxt        = ST_FLUSH;
                    pcjumpenable_nxt = 3'd0;
                    flush_nxt        = 1'b1;
                    fl_cnt_nxt       = FL_LOAD;
                    err_nxt          = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - 8'd1;
                end
            end
            ST_FLUSH: begin
                if (accept && !req_legal) err_nxt = 1'b1;
                if (fl_cnt != 3'd0) begin
                    fl_cnt_nxt = fl_cnt - 3'd1;
                    if (accept && req_legal) begin
                        pend_full_nxt   = 1'b1;
                        pend_kind_nxt   = rif.redirect_kind;
                        pend_offset_nxt = rif.redirect_offset;
                        pend_target_nxt = rif.redirect_target;
                        pend_base_nxt   = rif.fetch_prev_pc;
                    end
                end else if (pend_full) begin
                    load_en       = 1'b1;
                    ld_kind       = pend_kind;
                    ld_offset     = pend_offset;
                    ld_target     = pend_target;
                    ld_base       = pend_base;
                    pend_full_nxt = 1'b0;
                end else if (accept && req_legal) begin
                    load_en = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    flush_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (load_en) begin
            state_nxt        = ST_REDIRECT;
            cur_kind_nxt     = ld_kind;
            cur_base_nxt     = ld_base;
            cur_target_nxt   = kind_rel(ld_kind) ? (ld_base + {11'd0, ld_offset} - 20'd1)
                                                 : {14'd0, ld_target};
            pcjumpenable_nxt = ld_kind;
            pcchange_nxt     = ld_offset;
            pclocation_nxt   = cur_target_nxt[5:0];
            tmo_cnt_nxt      = TMO_LOAD;
            flush_nxt        = 1'b0;
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            cur_kind       <= 3'd0;
            cur_target     <= 20'd0;
            cur_base       <= 20'd0;
            pend_full      <= 1'b0;
            pend_kind      <= 3'd0;
            pend_offset    <= 9'd0;
            pend_target    <= 6'd0;
            pend_base      <= 20'd0;
            tmo_cnt        <= 8'd0;
            fl_cnt         <= 3'd0;
            pcjumpenable_q <= 3'd0;
            pcchange_q     <= 9'd0;
            pclocation_q   <= 6'd0;
            flush_q        <= 1'b0;
            link_valid_q   <= 1'b0;
            link_addr_q    <= 20'd0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state          <= state_nxt;
            cur_kind       <= cur_kind_nxt;
            cur_target     <= cur_target_nxt;
            cur_base       <= cur_base_nxt;
            pend_full      <= pend_full_nxt;
            pend_kind      <= pend_kind_nxt;
            pend_offset    <= pend_offset_nxt;
            pend_target    <= pend_target_nxt;
            pend_base      <= pend_base_nxt;
            tmo_cnt        <= tmo_cnt_nxt;
            fl_cnt         <= fl_cnt_nxt;
            pcjumpenable_q <= pcjumpenable_nxt;
            pcchange_q     <= pcchange_nxt;
            pclocation_q   <= pclocation_nxt;
            flush_q        <= flush_nxt;
            link_valid_q   <= link_valid_nxt;
            link_addr_q    <= link_addr_nxt;
            busy_q         <= busy_nxt;
            err_q          <= err_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: vector table, directed multi-cycle sequences and
// random traffic checked against a queue-based model of the redirect rules.
module tb_fetch_redirect_ctrl;
    localparam int FLUSH_CYCLES = 2;
    localparam int TIMEOUT      = 15;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_redirect_ctrl_if rif ();

    fetch_redirect_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .rif   (rif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [2:0]  kind;
        logic [8:0]  off;
        logic [5:0]  tgt;
        logic [19:0] fpc;
        logic [19:0] prev;
        logic        e_ready;
        logic [2:0]  e_pcje;
        logic        chk_pc;
        logic [8:0]  e_pcchange;
        logic [5:0]  e_pcloc;
        logic        e_flush;
        logic        e_link;
        logic [19:0] e_laddr;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [2:0]  kind;
        logic [8:0]  off;
        logic [19:0] tgt;
        logic [19:0] link;
    } req_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    // reference model state
    req_t        q[$];
    int          m_mode = 0;   // 0 idle, 1 redirecting, 2 flushing
    int          m_age  = 0;
    int          m_fl   = 0;
    logic        e_err  = 1'b0;
    logic        e_link = 1'b0;
    logic [19:0] e_laddr = 20'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] k, input logic [8:0] off,
                         input logic [5:0] t, input logic [19:0] fpc, input logic [19:0] prev);
        rif.redirect_valid  = v;
        rif.redirect_kind   = k;
        rif.redirect_offset = off;
        rif.redirect_target = t;
        rif.fetch_pc        = fpc;
        rif.fetch_prev_pc   = prev;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_core(input string tag, input logic [2:0] pcje, input logic fl,
                            input logic lv, input logic bz, input logic er);
        chk({tag, " pcjumpenable"}, 32'(rif.pcjumpenable), 32'(pcje));
        chk({tag, " flush"}, 32'(rif.flush), 32'(fl));
        chk({tag, " link_valid"}, 32'(rif.link_valid), 32'(lv));
        chk({tag, " busy"}, 32'(rif.busy), 32'(bz));
        chk({tag, " err"}, 32'(rif.err), 32'(er));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_core(tag, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, " pcchange"}, 32'(rif.pcchange), 32'd0);
        chk({tag, " pclocation"}, 32'(rif.pclocation), 32'd0);
        chk({tag, " link_addr"}, 32'(rif.link_addr), 32'd0);
        chk({tag, " ready"}, 32'(rif.redirect_ready), 32'd1);
    endtask

    function automatic vec_t mk(input logic v, input logic [2:0] k, input logic [8:0] off,
                                input logic [5:0] t, input logic [19:0] fpc, input logic [19:0] prev,
                                input logic rdy, input logic [2:0] pcje, input logic cpc,
                                input logic [8:0] pcc, input logic [5:0] pcl, input logic fl,
                                input logic lv, input logic [19:0] la, input logic bz, input logic er);
        vec_t r;
        r.v = v; r.kind = k; r.off = off; r.tgt = t; r.fpc = fpc; r.prev = prev;
        r.e_ready = rdy; r.e_pcje = pcje; r.chk_pc = cpc; r.e_pcchange = pcc; r.e_pcloc = pcl;
        r.e_flush = fl; r.e_link = lv; r.e_laddr = la; r.e_busy = bz; r.e_err = er;
        return r;
    endfunction

    function automatic req_t mkreq(input logic [2:0] k, input logic [8:0] off,
                                   input logic [5:0] t6, input logic [19:0] prev);
        req_t r;
        r.kind = k;
        r.off  = off;
        if (k == 3'd1 || k == 3'd4) r.tgt = 20'((int'(prev) + int'(off) - 1) & 32'hFFFFF);
        else                        r.tgt = {14'd0, t6};
        r.link = prev + 20'd1;
        return r;
    endfunction

    function automatic logic m_ready();
        return (m_mode == 0) || (q.size() < 2);
    endfunction

    task automatic m_step(input logic v, input logic [2:0] k, input logic [8:0] off,
                          input logic [5:0] t6, input logic [19:0] fpc, input logic [19:0] prev,
                          input logic rst);
        logic acc, legal;
        e_err  = 1'b0;
        e_link = 1'b0;
        if (rst) begin
            q.delete();
            m_mode = 0; m_age = 0; m_fl = 0;
            return;
        end
        acc   = v && m_ready();
        legal = (k >= 3'd1) && (k <= 3'd4);
        if (acc && !legal) e_err = 1'b1;
        if (m_mode == 0) begin
            if (acc && legal) begin
                q.push_back(mkreq(k, off, t6, prev));
                m_mode = 1; m_age = 0;
            end
        end else if (m_mode == 1) begin
            if (acc && legal) q.push_back(mkreq(k, off, t6, prev));
            m_age++;
            if (fpc == q[0].tgt) begin
                m_mode = 2; m_fl = 0;
                if (q[0].kind == 3'd3 || q[0].kind == 3'd4) begin
                    e_link  = 1'b1;
                    e_laddr = q[0].link;
                end
            end else if (m_age == TIMEOUT) begin
                e_err = 1'b1;
                m_mode = 2; m_fl = 0;
            end
        end else begin
            if (acc && legal) q.push_back(mkreq(k, off, t6, prev));
            m_fl++;
            if (m_fl == FLUSH_CYCLES) begin
                void'(q.pop_front());
                if (q.size() > 0) begin
                    m_mode = 1; m_age = 0;
                end else begin
                    m_mode = 0;
                end
            end
        end
    endtask

    initial begin
        logic        rv, rrst, exp_rdy;
        logic [2:0]  rk;
        logic [8:0]  roff;
        logic [5:0]  rt;
        logic [19:0] rfpc, rprev;
        int          match_pct;

        vecs[0]  = mk(1'b1, 3'd1, 9'd9, 6'h00, 20'h00000, 20'h00010, 1'b1, 3'd1, 1'b1, 9'd9, 6'h18, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00011, 20'h00010, 1'b1, 3'd1, 1'b1, 9'd9, 6'h18, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00012, 20'h00010, 1'b1, 3'd1, 1'b1, 9'd9, 6'h18, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00018, 20'h00010, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b1, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b1, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 3'd3, 9'd0, 6'h2A, 20'h00000, 20'h00100, 1'b1, 3'd3, 1'b1, 9'd0, 6'h2A, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h0002A, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b1, 1'b1, 20'h00101, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b1, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 3'd1, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd1, 1'b1, 9'd0, 6'h3F, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'hFFFFF, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b1, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b1, 1'b0, 20'h0, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        vecs[14] = mk(1'b1, 3'd6, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        vecs[15] = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        vecs[16] = mk(1'b1, 3'd0, 9'd5, 6'h05, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 3'd0, 9'd0, 6'h00, 20'h00000, 20'h00000, 1'b1, 3'd0, 1'b0, 9'd0, 6'h00, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);

        drive(1'b0, 3'd0, 9'd0, 6'd0, 20'd0, 20'd0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_reset_vals("init");

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].kind, vecs[i].off, vecs[i].tgt, vecs[i].fpc, vecs[i].prev);
            #1;
            chk($sformatf("vec%0d ready", i), 32'(rif.redirect_ready), 32'(vecs[i].e_ready));
            step();
            chk_core($sformatf("vec%0d", i), vecs[i].e_pcje, vecs[i].e_flush, vecs[i].e_link,
                     vecs[i].e_busy, vecs[i].e_err);
            if (vecs[i].chk_pc) begin
                chk($sformatf("vec%0d pcchange", i), 32'(rif.pcchange), 32'(vecs[i].e_pcchange));
                chk($sformatf("vec%0d pclocation", i), 32'(rif.pclocation), 32'(vecs[i].e_pcloc));
            end
            if (vecs[i].e_link)
                chk($sformatf("vec%0d link_addr", i), 32'(rif.link_addr), 32'(vecs[i].e_laddr));
        end

        // back-to-back: second request queued during REDIRECT, third held off
        drive(1'b1, 3'd1, 9'd4, 6'd0, 20'h0, 20'h00020);
        step();
        chk_core("b2b r1", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b r1 pclocation", 32'(rif.pclocation), 32'h23);
        drive(1'b1, 3'd2, 9'd0, 6'h15, 20'h0, 20'h00030);
        #1;
        chk("b2b ready slot empty", 32'(rif.redirect_ready), 32'd1);
        step();
        chk("b2b ready slot full", 32'(rif.redirect_ready), 32'd0);
        drive(1'b1, 3'd2, 9'd0, 6'h07, 20'h0, 20'h00040);
        step();
        chk_core("b2b hold", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b ready hold", 32'(rif.redirect_ready), 32'd0);
        drive(1'b1, 3'd2, 9'd0, 6'h07, 20'h00023, 20'h00040);
        step();
        chk_core("b2b flush1", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("b2b ready flush1", 32'(rif.redirect_ready), 32'd0);
        drive(1'b1, 3'd2, 9'd0, 6'h07, 20'h0, 20'h00040);
        step();
        chk_core("b2b flush2", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("b2b ready flush2", 32'(rif.redirect_ready), 32'd0);
        step();
        chk_core("b2b r2", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b r2 pclocation", 32'(rif.pclocation), 32'h15);
        chk("b2b ready r2", 32'(rif.redirect_ready), 32'd1);
        drive(1'b1, 3'd2, 9'd0, 6'h07, 20'h00015, 20'h00040);
        step();
        chk_core("b2b r2 flush1", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("b2b ready r3 queued", 32'(rif.redirect_ready), 32'd0);
        drive(1'b0, 3'd0, 9'd0, 6'd0, 20'h0, 20'h0);
        step();
        chk_core("b2b r2 flush2", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_core("b2b r3", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b r3 pclocation", 32'(rif.pclocation), 32'h07);
        drive(1'b0, 3'd0, 9'd0, 6'd0, 20'h00007, 20'h0);
        step();
        chk_core("b2b r3 flush1", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 9'd0, 6'd0, 20'h0, 20'h0);
        step();
        step();
        chk_core("b2b idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // timeout: target 0x42 never reached
        drive(1'b1, 3'd1, 9'd3, 6'd0, 20'h0, 20'h00040);
        step();
        drive(1'b0, 3'd0, 9'd0, 6'd0, 20'h0, 20'h0);
        chk_core("tmo c1", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= TIMEOUT; i++) begin
            step();
            chk_core($sformatf("tmo c%0d", i), 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        step();
        chk_core("tmo err", 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk_core("tmo flush2", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_core("tmo idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-REDIRECT with a pending request
        drive(1'b1, 3'd1, 9'd2, 6'd0, 20'h0, 20'h00050);
        step();
        drive(1'b1, 3'd2, 9'd0, 6'h11, 20'h0, 20'h00060);
        step();
        chk("rst pend ready", 32'(rif.redirect_ready), 32'd0);
        drive(1'b0, 3'd0, 9'd0, 6'd0, 20'h0, 20'h0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_reset_vals("midrst");
        drive(1'b0, 3'd0, 9'd0, 6'd0, 20'h00011, 20'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_core($sformatf("midrst after%0d", i), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // random traffic against the model
        match_pct = 15;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 150 == 0) begin
                case ($urandom_range(0, 2))
                    0:       match_pct = 0;
                    1:       match_pct = 15;
                    default: match_pct = 50;
                endcase
            end
            rv = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 15) < 13) rk = 3'($urandom_range(1, 4));
            else if ($urandom_range(0, 1) == 0) rk = 3'd0;
            else rk = 3'($urandom_range(5, 7));
            roff  = 9'($urandom_range(0, 511));
            rt    = 6'($urandom_range(0, 63));
            rprev = 20'($urandom);
            if (m_mode == 1 && $urandom_range(0, 99) < match_pct) rfpc = q[0].tgt;
            else rfpc = 20'($urandom);
            rrst = ($urandom_range(0, 299) == 0);

            drive(rv, rk, roff, rt, rfpc, rprev);
            reset = rrst;
            exp_rdy = m_ready();
            #1;
            chk($sformatf("rnd%0d ready", cyc), 32'(rif.redirect_ready), 32'(exp_rdy));
            m_step(rv, rk, roff, rt, rfpc, rprev, rrst);
            step();
            reset = 1'b0;
            if (rrst) begin
                chk_reset_vals($sformatf("rnd%0d rst", cyc));
            end else begin
                chk_core($sformatf("rnd%0d", cyc), (m_mode == 1) ? q[0].kind : 3'd0,
                         (m_mode == 2), e_link, (m_mode != 0), e_err);
                if (m_mode == 1) begin
                    chk($sformatf("rnd%0d pcchange", cyc), 32'(rif.pcchange), 32'(q[0].off));
                    chk($sformatf("rnd%0d pclocation", cyc), 32'(rif.pclocation), 32'(q[0].tgt[5:0]));
                end
                if (e_link)
                    chk($sformatf("rnd%0d link_addr", cyc), 32'(rif.link_addr), 32'(e_laddr));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
